// File: rtl/onehot_sequencer.sv
// One-hot position sequencer: loads, steps up/down with modulo wrap, and pulses wrap at end of range.
// Optional bounce (ping-pong) mode is compiled in with `define ONEHOT_SEQ_BOUNCE_EN.
module onehot_sequencer #(
   parameter int N = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                load,
   input  logic [N-1:0]        in,
   input  logic                dir,
`ifdef ONEHOT_SEQ_BOUNCE_EN
   input  logic                bounce,
`endif
   output logic [(1<<N)-1:0]   out,
   output logic [N-1:0]        idx,
   output logic                wrap
);

   localparam int M = 2**N;
   localparam logic [M-1:0] OUT_RST = {{(M-1){1'b0}}, 1'b1};
   localparam logic [N-1:0] IDX_TOP = N'(M-1);

   logic [N-1:0] idx_q, idx_d;
   logic [M-1:0] out_q, out_d;
   logic         wrap_q, wrap_d;
   logic         eff_dir;
   logic         at_end;

`ifdef ONEHOT_SEQ_BOUNCE_EN
   localparam logic [N-1:0] IDX_TOP_IN = N'(M-2);
   localparam logic [N-1:0] IDX_BOT_IN = N'(1);
   logic flip_q, flip_d;
   assign eff_dir = dir ^ flip_q;
`else
   assign eff_dir = dir;
`endif

   // A step from this position in the effective direction crosses the end of range.
   assign at_end = eff_dir ? (idx_q == '0) : (idx_q == IDX_TOP);

   always_comb begin
      idx_d  = idx_q;
      wrap_d = 1'b0;
`ifdef ONEHOT_SEQ_BOUNCE_EN
      flip_d = flip_q;
`endif
      if (load) begin
         idx_d = in;
`ifdef ONEHOT_SEQ_BOUNCE_EN
         flip_d = 1'b0;
`endif
      end else if (en) begin
         idx_d  = eff_dir ? (idx_q - N'(1)) : (idx_q + N'(1));
         wrap_d = at_end;
`ifdef ONEHOT_SEQ_BOUNCE_EN
         if (at_end && bounce) begin
            idx_d  = eff_dir ? IDX_BOT_IN : IDX_TOP_IN;
            flip_d = ~flip_q;
         end
`endif
      end
      out_d = OUT_RST << idx_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         out_q  <= OUT_RST;
         wrap_q <= 1'b0;
`ifdef ONEHOT_SEQ_BOUNCE_EN
         flip_q <= 1'b0;
`endif
      end else begin
         idx_q  <= idx_d;
         out_q  <= out_d;
         wrap_q <= wrap_d;
`ifdef ONEHOT_SEQ_BOUNCE_EN
         flip_q <= flip_d;
`endif
      end
   end

   assign out  = out_q;
   assign idx  = idx_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_onehot_sequencer.sv
// Self-checking bench for onehot_sequencer: vector table, reset corner cases and random run vs. a
// position/direction model. Bounce checks are included when ONEHOT_SEQ_BOUNCE_EN is defined.
module tb_onehot_sequencer;

   logic clk;
   logic rst_n;

   logic       en3, load3, dir3;
   logic [2:0] in3, idx3;
   logic [7:0] out3;
   logic       wrap3;

   logic        en4, load4, dir4;
   logic [3:0]  in4, idx4;
   logic [15:0] out4;
   logic        wrap4;

`ifdef ONEHOT_SEQ_BOUNCE_EN
   logic       bounce3;
   logic       en2, load2, dir2, bounce2;
   logic [1:0] in2, idx2;
   logic [3:0] out2;
   logic       wrap2;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   onehot_sequencer #(.N(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .en(en3), .load(load3), .in(in3), .dir(dir3),
`ifdef ONEHOT_SEQ_BOUNCE_EN
      .bounce(bounce3),
`endif
      .out(out3), .idx(idx3), .wrap(wrap3)
   );

   onehot_sequencer #(.N(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en4), .load(load4), .in(in4), .dir(dir4),
`ifdef ONEHOT_SEQ_BOUNCE_EN
      .bounce(1'b0),
`endif
      .out(out4), .idx(idx4), .wrap(wrap4)
   );

`ifdef ONEHOT_SEQ_BOUNCE_EN
   onehot_sequencer #(.N(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en2), .load(load2), .in(in2), .dir(dir2),
      .bounce(bounce2), .out(out2), .idx(idx2), .wrap(wrap2)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       ld;
      logic       e;
      logic       d;
      logic [2:0] inv;
      int         e_idx;
      bit         e_wrap;
   } vec_t;

   vec_t tbl[64];
   int   n_tbl = 0;

   // reference model state for the N=3 instance
   int m_idx;
   bit m_flip;
   bit m_wrap;

   task automatic add(input logic ld, input logic e, input logic d, input logic [2:0] inv,
                      input int ei, input bit ew);
      tbl[n_tbl] = '{ld: ld, e: e, d: d, inv: inv, e_idx: ei, e_wrap: ew};
      n_tbl++;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [3:0] a_idx, input logic [15:0] a_out,
                      input logic a_wrap, input int e_idx, input bit e_wrap);
      logic [15:0] e_out;
      e_out = 16'd1 << e_idx;
      n_checks++;
      if (a_idx !== 4'(e_idx) || a_out !== e_out || a_wrap !== e_wrap) begin
         n_fail++;
         $display("FAIL %s: got idx=%0d out=0x%0h wrap=%0b, expected idx=%0d out=0x%0h wrap=%0b",
                  nm, a_idx, a_out, a_wrap, e_idx, e_out, e_wrap);
      end
   endtask

   task automatic model_reset;
      m_idx = 0; m_flip = 1'b0; m_wrap = 1'b0;
   endtask

   // Position walks on the integer line 0..7; leaving the line either wraps or reflects.
   task automatic model_step(input bit ld, input bit e, input bit d, input bit b, input int inval);
      int stp, np;
      m_wrap = 1'b0;
      if (ld) begin
         m_idx  = inval;
         m_flip = 1'b0;
      end else if (e) begin
         stp = (d ^ m_flip) ? -1 : 1;
         np  = m_idx + stp;
         if (np < 0 || np > 7) begin
            m_wrap = 1'b1;
            if (b) begin
               np     = m_idx - stp;
               m_flip = !m_flip;
            end else begin
               np = (np + 8) % 8;
            end
         end
         m_idx = np;
      end
   endtask

   task automatic do_reset;
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   initial begin
      bit b;
      rst_n = 1'b1;
      en3 = 0; load3 = 0; dir3 = 0; in3 = '0;
      en4 = 0; load4 = 0; dir4 = 0; in4 = '0;
`ifdef ONEHOT_SEQ_BOUNCE_EN
      bounce3 = 0; en2 = 0; load2 = 0; dir2 = 0; in2 = '0; bounce2 = 0;
`endif

      // up 9 from reset
      for (int i = 1; i <= 9; i++) add(0, 1, 0, 3'd0, i % 8, i == 8);
      // load 5 then down 6
      add(1, 0, 0, 3'd5, 5, 0);
      for (int i = 4; i >= -1; i--) add(0, 1, 1, 3'd0, (i + 8) % 8, i == -1);
      // load beats step, then hold
      add(1, 1, 0, 3'd2, 2, 0);
      for (int i = 0; i < 4; i++) add(0, 0, 1, 3'd6, 2, 0);
      // load at top with en: no wrap from a load
      add(1, 0, 0, 3'd7, 7, 0);
      add(1, 1, 0, 3'd0, 0, 0);
      // direction reversal every step across the boundary
      add(0, 1, 1, 3'd0, 7, 1);
      add(0, 1, 0, 3'd0, 0, 1);
      add(0, 1, 0, 3'd0, 1, 0);
      add(0, 1, 1, 3'd0, 0, 0);

      // asynchronous reset before any clock edge
      #2 rst_n = 1'b0;
      #1;
      chk("reset_async", {1'b0, idx3}, {8'h0, out3}, wrap3, 0, 0);
      en3 = 1'b1;
      tick();
      chk("reset_held", {1'b0, idx3}, {8'h0, out3}, wrap3, 0, 0);
      #1 rst_n = 1'b1;

      for (int i = 0; i < n_tbl; i++) begin
         load3 = tbl[i].ld; en3 = tbl[i].e; dir3 = tbl[i].d; in3 = tbl[i].inv;
         tick();
         chk($sformatf("tbl[%0d]", i), {1'b0, idx3}, {8'h0, out3}, wrap3,
             tbl[i].e_idx, tbl[i].e_wrap);
      end
      en3 = 0; load3 = 0;

      // N=4: climb to 9, reset between edges, resume from 0
      do_reset();
      en4 = 1'b1; dir4 = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         tick();
         chk($sformatf("n4_up%0d", i), idx4, out4, wrap4, i, 0);
      end
      #1 rst_n = 1'b0;
      #1;
      chk("n4_mid_reset", idx4, out4, wrap4, 0, 0);
      #1 rst_n = 1'b1;
      tick();
      chk("n4_after_reset", idx4, out4, wrap4, 1, 0);
      en4 = 1'b0;

`ifdef ONEHOT_SEQ_BOUNCE_EN
      do_reset();
      en2 = 1'b1; dir2 = 1'b0; bounce2 = 1'b1;
      begin
         int exp2[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
         for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("bounce_n2[%0d]", i), {2'b0, idx2}, {12'h0, out2}, wrap2,
                exp2[i], (i == 3) || (i == 6));
         end
      end
      en2 = 1'b0; bounce2 = 1'b0;
`endif

      // random run against the model, with one mid-run reset
      do_reset();
      model_reset();
      for (int i = 0; i < 400; i++) begin
         if (i == 200) begin
            #1 rst_n = 1'b0;
            #1;
            model_reset();
            chk("rand_reset", {1'b0, idx3}, {8'h0, out3}, wrap3, 0, 0);
            rst_n = 1'b1;
         end
         load3 = ($urandom_range(0, 9) == 0);
         en3   = ($urandom_range(0, 3) != 0);
         dir3  = ($urandom_range(0, 5) == 0) ? ~dir3 : dir3;
         in3   = 3'($urandom_range(0, 7));
         b     = 1'b0;
`ifdef ONEHOT_SEQ_BOUNCE_EN
         bounce3 = ($urandom_range(0, 1) == 1);
         b       = bounce3;
`endif
         tick();
         model_step(load3, en3, dir3, b, int'(in3));
         chk($sformatf("rand[%0d]", i), {1'b0, idx3}, {8'h0, out3}, wrap3, m_idx, m_wrap);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/onehot_sequencer.md
ONEHOT_SEQUENCER -- requirements
Module: onehot_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 3, the binary index width (N >= 1).
REQ-002 The block SHALL derive localparam M = 2**N, the one-hot output width; M SHALL NOT be overridable.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  step enable; one step per cycle while high.
REQ-006 load  input  1  synchronous load of position from in.
REQ-007 in  input  N  binary position loaded when load=1.
REQ-008 dir  input  1  step direction: 0 = up (index+1), 1 = down (index-1).
REQ-009 out  output  M  registered one-hot position, exactly one bit set at all times.
REQ-010 idx  output  N  registered binary index of the set bit of out.
REQ-011 wrap  output  1  registered one-cycle pulse marking an end-of-range event.

Function
REQ-012 out and idx SHALL be driven directly from flops; out SHALL equal 1 << idx in every cycle.
REQ-013 Priority per edge SHALL be: load > step (en=1) > hold.
REQ-014 load=1 SHALL set idx to in and out to the decode of in on the next edge, regardless of en and dir; wrap SHALL be 0 that cycle.
REQ-015 en=1, load=0, dir=0 SHALL advance idx by 1 on the next edge; from M-1 it SHALL go to 0.
REQ-016 en=1, load=0, dir=1 SHALL decrement idx by 1 on the next edge; from 0 it SHALL go to M-1.
REQ-017 wrap SHALL be 1 for exactly the cycle following a step that crosses the end of range (M-1->0 up, 0->M-1 down, or a bounce turnaround per REQ-024), else 0.
REQ-018 en=0, load=0 SHALL hold idx and out; wrap SHALL be 0.
REQ-019 dir SHALL be sampled every stepping cycle; changing dir mid-sequence SHALL reverse on that edge with no dead cycle.
REQ-020 Index arithmetic SHALL be modulo 2**N on N bits; no out-of-range or zero/multi-hot out state SHALL be reachable.
REQ-021 Latency from any input to out/idx/wrap SHALL be exactly one clock edge.

Reset
REQ-022 rst_n=0 SHALL immediately (without clk) force idx=0, out=1 (bit 0 only), wrap=0, and any bounce state cleared; outputs SHALL stay there while rst_n=0.
REQ-023 Reset asserted mid-sequence SHALL abandon the sequence; after release the first edge SHALL act on inputs from position 0.

Configuration
REQ-024 Macro ONEHOT_SEQ_BOUNCE_EN defined: block SHALL add input port bounce (1 bit) and an internal flip flop flip_q; effective direction = dir XOR flip_q; when bounce=1 a step that would cross the end of range SHALL instead move one position inward and toggle flip_q (N=2 up: 0,1,2,3,2,1,0,1,...), with wrap pulsed after each turnaround; when bounce=0 REQ-015/016 wrapping SHALL apply and flip_q SHALL hold.
REQ-025 With ONEHOT_SEQ_BOUNCE_EN defined, load=1 SHALL clear flip_q; for N=1 bounce SHALL toggle 0,1,0,1.
REQ-026 Macro undefined: port bounce and flip_q SHALL NOT exist; effective direction = dir; behaviour SHALL be REQ-012..023 only.

Verification
REQ-027 N=3, reset then release, en=1, dir=0 for 9 cycles -> idx 1,2,...,7,0,1; out 0x02..0x80,0x01,0x02; wrap=1 only in cycle after 7->0.
REQ-028 N=3, load=1 in=5 -> idx=5, out=0x20; then en=1 dir=1 x6 -> idx 4,3,2,1,0,7; wrap=1 after 0->7.
REQ-029 N=3, load=1 and en=1 same cycle with in=2 -> idx=2 (load wins), wrap=0; en=0 for 4 cycles -> idx holds 2.
REQ-030 N=4, stepping up to idx=9, assert rst_n=0 between edges -> out=0x0001, idx=0 immediately; release, en=1 dir=0 -> idx=1 next edge.
REQ-031 ONEHOT_SEQ_BOUNCE_EN, N=2, bounce=1, en=1, dir=0 from reset for 8 cycles -> idx 1,2,3,2,1,0,1,2; wrap=1 after steps into 2 (from 3) and into 1 (from 0).
REQ-032 Every scenario: assert out is one-hot and out == 1 << idx each cycle.
